// File: rtl/accum_seq.sv
// accum_seq: sequential 8-bit add/subtract accumulator over N_OPS operands
// with ready/valid handshakes and carry, sticky overflow and zero flags.
module accum_seq #(
    parameter int N_OPS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_sub,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       carry,
    output logic       ovf,
    output logic       zero,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t     state, state_nx;
    logic [7:0] cnt;
    logic [7:0] b;
    logic [8:0] sum;
    logic       accept;
    logic       last;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;

    always_comb begin
        state_nx  = state;
        in_ready  = state == ACC;
        res_valid = state == DONE;
        busy      = state != IDLE;
        accept    = in_ready && in_valid;
        last      = cnt == 8'(N_OPS - 1);
        if (state == IDLE && start)   state_nx = ACC;
        if (accept && last)           state_nx = DONE;
        if (res_valid && res_ready)   state_nx = IDLE;
    end

    // Subtraction is acc + ~Y + 1, so carry doubles as "no borrow".
    always_comb begin
        b   = in_sub ? ~in_data : in_data;
        sum = {1'b0, res_data} + {1'b0, b} + {8'd0, in_sub};
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            res_data <= 8'd0;
            cnt      <= 8'd0;
            carry    <= 1'b0;
            ovf      <= 1'b0;
        end else if (state == IDLE && start) begin
            res_data <= 8'd0;
            cnt      <= 8'd0;
            carry    <= 1'b0;
            ovf      <= 1'b0;
        end else if (accept) begin
            res_data <= sum[7:0];
            cnt      <= cnt + 8'd1;
            carry    <= sum[8];
            ovf      <= ovf | ((res_data[7] == b[7]) && (sum[7] != res_data[7]));
        end

    assign zero = res_data == 8'd0;
endmodule

// File: tb/tb_accum_seq.sv
// tb_accum_seq: directed and randomized sequences for accum_seq, checked
// against an integer-arithmetic reference model.
module tb_accum_seq;
    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'd0;
    logic       in_sub = 1'b0;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [7:0] res_data;
    logic       carry;
    logic       ovf;
    logic       zero;
    logic       busy;

    int         checks = 0;
    int         passes = 0;
    logic [7:0] op_d [N];
    logic       op_s [N];
    int         m_acc;
    logic       m_carry;
    logic       m_ovf;

    accum_seq #(.N_OPS(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .in_sub(in_sub),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .carry(carry), .ovf(ovf), .zero(zero), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int sgn(input int v);
        return v > 127 ? v - 256 : v;
    endfunction

    task automatic model_op(input logic [7:0] y, input logic s);
        int a, r, sr;
        a  = m_acc;
        r  = s ? a - int'(y) : a + int'(y);
        sr = s ? sgn(a) - sgn(int'(y)) : sgn(a) + sgn(int'(y));
        m_carry = s ? (a >= int'(y)) : (r > 255);
        m_ovf   = m_ovf | (sr > 127) | (sr < -128);
        m_acc   = r & 255;
    endtask

    task automatic set_ops(input logic [7:0] d0, d1, d2, d3, input logic [3:0] s);
        op_d[0] = d0; op_d[1] = d1; op_d[2] = d2; op_d[3] = d3;
        for (int k = 0; k < N; k++) op_s[k] = s[k];
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_data"}, res_data, 8'h00);
        chk({tag, "_carry"}, {7'd0, carry}, 8'd0);
        chk({tag, "_ovf"}, {7'd0, ovf}, 8'd0);
        chk({tag, "_zero"}, {7'd0, zero}, 8'd1);
        chk({tag, "_in_ready"}, {7'd0, in_ready}, 8'd0);
        chk({tag, "_res_valid"}, {7'd0, res_valid}, 8'd0);
        chk({tag, "_busy"}, {7'd0, busy}, 8'd0);
    endtask

    task automatic check_result(input string tag);
        chk({tag, "_data"}, res_data, 8'(m_acc));
        chk({tag, "_carry"}, {7'd0, carry}, {7'd0, m_carry});
        chk({tag, "_ovf"}, {7'd0, ovf}, {7'd0, m_ovf});
        chk({tag, "_zero"}, {7'd0, zero}, {7'd0, m_acc == 0});
    endtask

    // rnd: random in_valid gaps and stray start pulses; hold: cycles with res_ready low
    task automatic run(input bit rnd, input int hold);
        int  lat, i, tries;
        logic took;
        m_acc = 0; m_carry = 1'b0; m_ovf = 1'b0;
        start = 1'b1;
        step;
        start = 1'b0;
        lat = 1; i = 0; tries = 0;
        while (i < N) begin
            in_valid = (rnd && tries < 40) ? 1'($urandom_range(0, 1)) : 1'b1;
            start    = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            in_data  = op_d[i];
            in_sub   = op_s[i];
            chk("acc_in_ready", {7'd0, in_ready}, 8'd1);
            chk("acc_busy", {7'd0, busy}, 8'd1);
            chk("acc_res_valid", {7'd0, res_valid}, 8'd0);
            took = in_valid;
            step;
            lat++; tries++;
            if (took) begin
                model_op(op_d[i], op_s[i]);
                i++;
                if (i < N) begin
                    chk("mid_data", res_data, 8'(m_acc));
                    chk("mid_carry", {7'd0, carry}, {7'd0, m_carry});
                end
            end
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (!rnd) chk("latency", 8'(lat), 8'(N + 1));
        for (int h = 0; h < hold; h++) begin
            start = h[0];
            chk("done_res_valid", {7'd0, res_valid}, 8'd1);
            chk("done_in_ready", {7'd0, in_ready}, 8'd0);
            chk("done_busy", {7'd0, busy}, 8'd1);
            check_result("done_hold");
            step;
        end
        start = 1'b0;
        chk("done_res_valid", {7'd0, res_valid}, 8'd1);
        check_result("done");
        res_ready = 1'b1;
        step;
        res_ready = 1'b0;
        chk("idle_res_valid", {7'd0, res_valid}, 8'd0);
        chk("idle_busy", {7'd0, busy}, 8'd0);
        check_result("idle_held");
    endtask

    initial begin
        #1;
        check_reset_vals("por");
        #3 rst_n = 1'b1;
        step;
        check_reset_vals("post_release");

        set_ops(8'h10, 8'h20, 8'h30, 8'h40, 4'b0000);
        run(1'b0, 0);
        chk("r031_data", res_data, 8'hA0);
        chk("r031_ovf", {7'd0, ovf}, 8'd1);

        set_ops(8'h01, 8'h01, 8'h8B, 8'h09, 4'b1001);
        run(1'b0, 2);
        chk("r032_data", res_data, 8'h82);
        chk("r032_carry", {7'd0, carry}, 8'd1);

        set_ops(8'h05, 8'h05, 8'h00, 8'h00, 4'b0010);
        run(1'b0, 1);
        chk("r033_data", res_data, 8'h00);

        set_ops(8'h10, 8'h20, 8'h30, 8'h40, 4'b0000);
        run(1'b1, 10);
        chk("r034_data", res_data, 8'hA0);

        // asynchronous reset in the middle of a sequence
        start = 1'b1;
        step;
        start = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_data = op_d[k];
            in_sub  = op_s[k];
            step;
        end
        chk("pre_rst_data", res_data, 8'h30);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("mid_rst");
        #1 rst_n = 1'b1;
        step;
        check_reset_vals("after_rst");

        set_ops(8'h05, 8'h05, 8'h00, 8'h00, 4'b0010);
        run(1'b0, 0);
        chk("r035_data", res_data, 8'h00);

        for (int t = 0; t < 20; t++) begin
            for (int k = 0; k < N; k++) begin
                op_d[k] = 8'($urandom);
                op_s[k] = 1'($urandom);
            end
            run(1'b1, int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
